rr_decode_arbiter: RTL and testbench
====================================

Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one 32-slot resource among 32 requesters.
- Registers a 5-bit winner index and expands it to a 32-bit one-hot grant using the team's standard 5-to-32 decode equations (bit i = AND of the index bits, each true or complemented to match i).
- Enforces hold/release handshake with a bounded tenure; sits between requester logic and the shared datapath's enable lines.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may stay asserted before forced release (legal 1..256).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  32  per-requester request, level-sensitive.
- done  input  1  current owner finished; sampled only while grant_valid=1.
- grant_valid  output  1  a grant is active.
- grant_idx  output  5  binary index of current owner (0 when idle).
- grant_onehot  output  32  decode of grant_idx, gated by grant_valid; all-zero when idle.
- timeout  output  1  one-cycle pulse: grant was revoked by MAX_HOLD.

Behaviour:
- Reset (reset=1 at a clk edge, synchronous, active-high): state=IDLE, ptr=0, hold_cnt=0, grant_valid=0, grant_idx=0, grant_onehot=0, timeout=0. Reset overrides every other event, including mid-grant; release is immediate, with no timeout pulse.
- All outputs are registered; grant_onehot is combinationally decoded from registered grant_idx AND grant_valid, so no combinational path from req or done to outputs.
- State IDLE:
  - If req != 0 at edge: winner = first set bit searching ptr, ptr+1, ... wrapping 31->0.
  - Next cycle: grant_idx=winner, grant_valid=1, hold_cnt=0, state=GRANT. Latency: 1 edge from req sampled to grant_valid high.
  - If req == 0: remain IDLE, outputs unchanged.
- State GRANT: evaluate release at each edge, in priority order:
  1. done=1: release, timeout=0.
  2. req[grant_idx]=0 (requester withdrew): release, timeout=0.
  3. hold_cnt == MAX_HOLD-1: release, timeout=1 for one cycle.
  4. Otherwise: hold_cnt increments, grant held.
- Release:
  - Next cycle: grant_valid=0, grant_onehot=0, grant_idx=0, state=IDLE, ptr=(released idx+1) mod 32 (5-bit natural wrap: 31->0).
  - Exactly one IDLE cycle separates consecutive grants, so at most one owner at any time and grant_onehot is always all-zero or exactly one bit.
- Max tenure: MAX_HOLD cycles of grant_valid=1. With MAX_HOLD=1, every grant lasts one cycle and times out unless done=1 at that edge.
- timeout is high only in the cycle immediately after a forced release; otherwise 0.
- done while IDLE is ignored.
- req bits other than grant_idx changing during GRANT have no effect until the next IDLE arbitration.
- hold_cnt width: ceil(log2(MAX_HOLD)), minimum 1 bit; it never wraps because release occurs at MAX_HOLD-1.
- Fairness: with all 32 requesting continuously, each index is granted once per 32 grants, in ascending order.

Test Plan:
- Reset: hold reset 3 cycles with req=32'hFFFFFFFF -> grant_valid=0, grant_onehot=0, timeout=0 throughout; first grant after reset drops is idx 0.
- Single requester: req=32'h00000020 with done pulsed 3 cycles after grant -> grant_idx=5, grant_onehot=32'h00000020, grant_valid high 4 cycles, then 1 idle cycle, then idx 5 again.
- Rotation and wrap: req=32'hFFFFFFFF, done=1 every grant cycle -> grant_idx sequence 0,1,...,31,0,1 with an idle cycle between each; grant_onehot = 1<<idx each time.
- Timeout: MAX_HOLD=4, req=32'h80000001, done=0 -> idx 0 held exactly 4 cycles, timeout=1 the following cycle, then idx 31 granted.
- Simultaneous done and limit: MAX_HOLD=4, done=1 on the 4th grant cycle -> release with timeout=0.
- Withdraw and reset mid-grant: drop req[grant_idx] mid-grant -> release next cycle, timeout=0. Assert reset while idx 7 is granted -> all outputs 0 next cycle; ptr=0, so next winner is the lowest set bit.

Source files
------------

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 32 requesters sharing one resource.
// Holds a registered 5-bit winner index, decodes it to a one-hot grant,
// and releases on done, on requester withdrawal, or after MAX_HOLD cycles.
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req,
    input  logic        done,
    output logic        grant_valid,
    output logic [4:0]  grant_idx,
    output logic [31:0] grant_onehot,
    output logic        timeout
);

    // Tenure counter only needs to reach MAX_HOLD-1, never wraps.
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            grant_valid_q, grant_valid_d;
    logic [4:0]      grant_idx_q, grant_idx_d;
    logic            timeout_q, timeout_d;

    logic            found;
    logic [4:0]      winner;
    logic [4:0]      cand;

    // Rotating priority search: first set request at ptr, ptr+1, ... (5-bit wrap).
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        cand   = ptr_q;
        for (int i = 0; i < 32; i++) begin
            cand = ptr_q + 5'(i);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/GRANT handshake.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        timeout_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // done is deliberately ignored here.
                if (found) begin
                    state_d       = GRANT;
                    grant_valid_d = 1'b1;
                    grant_idx_d   = winner;
                    hold_cnt_d    = '0;
                end
            end
            GRANT: begin
                if (done || !req[grant_idx_q] || (hold_cnt_q == HOLD_LAST)) begin
                    // Forced release only flags timeout when neither done nor withdraw fired.
                    timeout_d     = !done && req[grant_idx_q];
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    grant_idx_d   = '0;
                    hold_cnt_d    = '0;
                    ptr_d         = grant_idx_q + 5'd1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
                grant_idx_d   = '0;
            end
        endcase
    end

    // State register; synchronous reset wins over any in-flight grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            timeout_q     <= timeout_d;
        end
    end

    // 5-to-32 decode: each bit is the AND of index bits taken true or
    // complemented to match its position, gated by grant_valid.
    for (genvar gi = 0; gi < 32; gi++) begin : g_dec
        localparam logic [4:0] POS = 5'(gi);
        assign grant_onehot[gi] = grant_valid_q & (&(grant_idx_q ~^ POS));
    end

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter with MAX_HOLD=4.
module tb_rr_decode_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] req;
    logic        done;
    logic        grant_valid;
    logic [4:0]  grant_idx;
    logic [31:0] grant_onehot;
    logic        timeout;

    int n_chk = 0;
    int n_err = 0;

    rr_decode_arbiter #(.MAX_HOLD(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .done         (done),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full output check against an expected grant state.
    task automatic expect_out(input string tag, input logic gv, input logic [4:0] idx, input logic to);
        logic [31:0] oh;
        oh = gv ? (32'd1 << idx) : 32'd0;
        chk({tag, "_gv"},  {31'd0, grant_valid}, {31'd0, gv});
        chk({tag, "_idx"}, {27'd0, grant_idx},   {27'd0, (gv ? idx : 5'd0)});
        chk({tag, "_oh"},  grant_onehot,         oh);
        chk({tag, "_to"},  {31'd0, timeout},     {31'd0, to});
    endtask

    initial begin
        reset = 1'b1;
        req   = 32'hFFFF_FFFF;
        done  = 1'b0;

        // Reset held with everyone requesting: nothing granted.
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("rst", 1'b0, 5'd0, 1'b0);
        end
        reset = 1'b0;
        tick();
        expect_out("first", 1'b1, 5'd0, 1'b0);

        // Rotation with done every grant cycle: idle, then next index, wrapping.
        done = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            tick();
            expect_out("rot_idle", 1'b0, 5'd0, 1'b0);
            tick();
            expect_out("rot", 1'b1, 5'(k % 32), 1'b0);
        end
        // Now idx 1 granted, ptr will become 2.

        // Single requester on bit 5; current owner (1) withdraws.
        done = 1'b0;
        req  = 32'h0000_0020;
        tick();
        expect_out("wd_rel", 1'b0, 5'd0, 1'b0);
        tick();
        expect_out("one_g1", 1'b1, 5'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("one_hold", 1'b1, 5'd5, 1'b0);
        end
        // done coincides with tenure limit: release without timeout.
        done = 1'b1;
        tick();
        expect_out("done_lim", 1'b0, 5'd0, 1'b0);
        done = 1'b0;
        tick();
        expect_out("one_again", 1'b1, 5'd5, 1'b0);

        // Timeout: bits 0 and 31, ptr=6 after owner 5 withdraws -> 31 first.
        req = 32'h8000_0001;
        tick();
        expect_out("wd2_rel", 1'b0, 5'd0, 1'b0);
        tick();
        expect_out("to_g31", 1'b1, 5'd31, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("to_h31", 1'b1, 5'd31, 1'b0);
        end
        tick();
        expect_out("to_p31", 1'b0, 5'd0, 1'b1);
        tick();
        expect_out("to_g0", 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("to_h0", 1'b1, 5'd0, 1'b0);
        end
        tick();
        expect_out("to_p0", 1'b0, 5'd0, 1'b1);
        tick();
        expect_out("to_g31b", 1'b1, 5'd31, 1'b0);

        // Withdraw 31 mid-grant, then grant 7 alone.
        req = 32'h0000_0080;
        tick();
        expect_out("wd3_rel", 1'b0, 5'd0, 1'b0);
        tick();
        expect_out("g7", 1'b1, 5'd7, 1'b0);
        tick();
        expect_out("g7_hold", 1'b1, 5'd7, 1'b0);

        // Reset mid-grant; ptr returns to 0 so 7 beats 10.
        req   = 32'h0000_0480;
        reset = 1'b1;
        tick();
        expect_out("rst_mid", 1'b0, 5'd0, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("post_rst", 1'b1, 5'd7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
